// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types for the data-memory access controller: FSM states and the SRAM
// control bundle driven toward the single-port data SRAM.
package dmem_access_ctrl_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        DM_IDLE,
        DM_LOAD,
        DM_RD_WAIT
    } dmem_state_e;

    typedef struct packed {
        logic                   csb;
        logic                   web;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] din;
    } dmem_sram_if_t;

endpackage

// File: rtl/dmem_access_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module dmem_access_ctrl_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_inc && !(&r_count)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/dmem_access_ctrl.sv
// Arbitrates the single-port data SRAM between the bench loader (highest priority)
// and the MEM stage; pipeline loads take two cycles because SRAM read data is registered.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              EN,
    input  logic              START,
    input  logic              tb_load_ctrl,
    input  logic [ADDR_W-1:0] tb_load_addr,
    input  logic [DATA_W-1:0] tb_load_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stall_n,
    output logic              addr_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              sram_csb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    dmem_state_e       r_state;
    dmem_state_e       w_state_next;
    logic [DATA_W-1:0] r_rdata;
    logic              r_addr_err;

    dmem_sram_if_t     w_sram;
    logic              w_stall_n;
    logic [DATA_W-1:0] w_rdata;
    logic              w_rdata_load;
    logic              w_err_set;
    logic              w_misaligned;
    logic              w_oor;
    logic [ADDR_W-1:0] w_word_addr;

    assign w_misaligned = |mem_addr[1:0];
    assign w_oor        = |mem_addr[31:ADDR_W+2];
    assign w_word_addr  = mem_addr[ADDR_W+1:2];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= DM_IDLE;
            r_rdata    <= '0;
            r_addr_err <= 1'b0;
        end else if (EN) begin
            r_state <= w_state_next;
            if (w_rdata_load) begin
                r_rdata <= sram_dout;
            end
            if (w_err_set) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sram.csb   = 1'b1;
        w_sram.web   = 1'b1;
        w_sram.addr  = '0;
        w_sram.din   = '0;
        w_stall_n    = 1'b1;
        w_rdata      = r_rdata;
        w_rdata_load = 1'b0;
        w_err_set    = 1'b0;

        // While reset is held the SRAM stays deselected regardless of pending requests.
        if (!RSTn) begin
            w_state_next = DM_IDLE;
        end else if (!EN) begin
            w_stall_n = 1'b0;
        end else if (tb_load_ctrl) begin
            w_state_next = DM_LOAD;
            w_sram.csb   = 1'b0;
            w_sram.web   = 1'b0;
            w_sram.addr  = tb_load_addr;
            w_sram.din   = tb_load_data;
            w_stall_n    = 1'b0;
        end else if (r_state == DM_RD_WAIT) begin
            // The request still on the MEM inputs is the one completing here.
            w_state_next = DM_IDLE;
            w_rdata      = sram_dout;
            w_rdata_load = 1'b1;
        end else begin
            // IDLE, or the first cycle after the loader lets go: serve the pipeline.
            w_state_next = DM_IDLE;
            if (START && mem_req) begin
                w_err_set = w_misaligned | w_oor;
                if (w_oor) begin
                    if (!mem_we) begin
                        w_rdata = '0;
                    end
                end else begin
                    w_sram.csb  = 1'b0;
                    w_sram.addr = w_word_addr;
                    if (mem_we) begin
                        w_sram.web = 1'b0;
                        w_sram.din = mem_wdata;
                    end else begin
                        w_stall_n    = 1'b0;
                        w_state_next = DM_RD_WAIT;
                    end
                end
            end
        end
    end

    dmem_access_ctrl_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .i_clk   (CLK),
        .i_rst_n (RSTn),
        .i_inc   (EN & ~w_stall_n),
        .o_count (stall_cnt)
    );

    assign sram_csb  = w_sram.csb;
    assign sram_web  = w_sram.web;
    assign sram_addr = w_sram.addr;
    assign sram_din  = w_sram.din;
    assign stall_n   = w_stall_n;
    assign mem_rdata = w_rdata;
    assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: behavioural SRAM, reference memory and a queue of
// expected load data popped when the MEM stage sees stall_n=1.
module tb_dmem_access_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              CLK = 1'b0;
    logic              RSTn = 1'b0;
    logic              EN = 1'b0;
    logic              START = 1'b0;
    logic              tb_load_ctrl = 1'b0;
    logic [ADDR_W-1:0] tb_load_addr = '0;
    logic [DATA_W-1:0] tb_load_data = '0;
    logic              mem_req = 1'b0;
    logic              mem_we = 1'b0;
    logic [31:0]       mem_addr = '0;
    logic [DATA_W-1:0] mem_wdata = '0;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_n;
    logic              addr_err;
    logic [CNT_W-1:0]  stall_cnt;
    logic              sram_csb;
    logic              sram_web;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_din;
    logic [DATA_W-1:0] sram_dout;

    logic              sc_inc = 1'b0;
    logic [2:0]        sc_cnt;

    logic [DATA_W-1:0] sram_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ref_mem  [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] exp_q [$];

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    dmem_access_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .EN           (EN),
        .START        (START),
        .tb_load_ctrl (tb_load_ctrl),
        .tb_load_addr (tb_load_addr),
        .tb_load_data (tb_load_data),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .stall_n      (stall_n),
        .addr_err     (addr_err),
        .stall_cnt    (stall_cnt),
        .sram_csb     (sram_csb),
        .sram_web     (sram_web),
        .sram_addr    (sram_addr),
        .sram_din     (sram_din),
        .sram_dout    (sram_dout)
    );

    dmem_access_ctrl_sat_counter #(
        .CNT_W (3)
    ) u_sc (
        .i_clk   (CLK),
        .i_rst_n (RSTn),
        .i_inc   (sc_inc),
        .o_count (sc_cnt)
    );

    always @(posedge CLK) begin
        if (!sram_csb) begin
            if (!sram_web) sram_mem[sram_addr] <= sram_din;
            else           sram_dout <= sram_mem[sram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic next_cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic loader_write(input string tag, input logic [9:0] a, input logic [31:0] d);
        tb_load_ctrl = 1'b1;
        tb_load_addr = a;
        tb_load_data = d;
        ref_mem[a]   = d;
        @(negedge CLK);
        chk({tag, "_stall_n"}, stall_n, 0);
        chk({tag, "_csb"}, sram_csb, 0);
        chk({tag, "_web"}, sram_web, 0);
        chk({tag, "_addr"}, sram_addr, a);
        chk({tag, "_din"}, sram_din, d);
        next_cyc();
    endtask

    // One MEM-stage access held until stall_n=1 retires it; exp_lat in cycles.
    task automatic pipe_op(input string tag, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input int exp_lat);
        int         cyc = 0;
        logic       done = 1'b0;
        logic       oor;
        logic [9:0] w;
        oor       = (a[31:12] != 0);
        w         = a[11:2];
        mem_req   = 1'b1;
        mem_we    = we;
        mem_addr  = a;
        mem_wdata = wd;
        if (!we)       exp_q.push_back(oor ? 32'h0 : ref_mem[w]);
        else if (!oor) ref_mem[w] = wd;
        while (!done && cyc < 20) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 1) begin
                chk({tag, "_csb"}, sram_csb, oor);
                if (!oor) begin
                    chk({tag, "_web"}, sram_web, !we);
                    chk({tag, "_addr"}, sram_addr, w);
                    if (we) chk({tag, "_din"}, sram_din, wd);
                end
            end
            if (stall_n) begin
                done = 1'b1;
                if (!we && exp_q.size() > 0) chk({tag, "_rdata"}, mem_rdata, exp_q.pop_front());
            end
            next_cyc();
        end
        mem_req = 1'b0;
        chk({tag, "_latency"}, cyc, exp_lat);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #2;
        mem_req = 1'b1;
        @(negedge CLK);
        chk("rst_csb", sram_csb, 1);
        chk("rst_web", sram_web, 1);
        chk("rst_stall_n", stall_n, 1);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        mem_req = 1'b0;
        next_cyc();
        RSTn  = 1'b1;
        EN    = 1'b1;
        START = 1'b1;
        next_cyc();

        // 1: loader burst
        loader_write("t1a", 10'd5, 32'hDEADBEEF);
        loader_write("t1b", 10'd6, 32'h12345678);
        tb_load_ctrl = 1'b0;
        @(negedge CLK);
        chk("t1_after_stall_n", stall_n, 1);
        chk("t1_after_csb", sram_csb, 1);
        chk("t1_stall_cnt", stall_cnt, 2);
        next_cyc();

        // 2-3: load, store, load-after-store, back-to-back stores
        pipe_op("t2_ld", 1'b0, 32'h14, 32'h0, 2);
        pipe_op("t3_st", 1'b1, 32'h18, 32'hA5A5A5A5, 1);
        pipe_op("t3_ld", 1'b0, 32'h18, 32'h0, 2);
        pipe_op("t3_st2", 1'b1, 32'h20, 32'h0BADF00D, 1);
        pipe_op("t3_st3", 1'b1, 32'h24, 32'h600DCAFE, 1);
        pipe_op("t3_ld2", 1'b0, 32'h20, 32'h0, 2);
        pipe_op("t3_ld3", 1'b0, 32'h24, 32'h0, 2);
        chk("t3_stall_cnt", stall_cnt, 6);
        chk("t3_addr_err", addr_err, 0);

        // 4: loader preempts RD_WAIT, load reissued
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h14;
        exp_q.push_back(ref_mem[5]);
        @(negedge CLK);
        chk("t4_issue_stall_n", stall_n, 0);
        next_cyc();
        tb_load_ctrl = 1'b1;
        tb_load_addr = 10'd7;
        tb_load_data = 32'hCAFEF00D;
        ref_mem[7]   = 32'hCAFEF00D;
        @(negedge CLK);
        chk("t4_ld_stall_n", stall_n, 0);
        chk("t4_ld_web", sram_web, 0);
        chk("t4_ld_addr", sram_addr, 7);
        next_cyc();
        tb_load_ctrl = 1'b0;
        @(negedge CLK);
        chk("t4_reissue_stall_n", stall_n, 0);
        chk("t4_reissue_csb", sram_csb, 0);
        chk("t4_rdata_q_kept", mem_rdata, ref_mem[9]);
        next_cyc();
        @(negedge CLK);
        chk("t4_done_stall_n", stall_n, 1);
        if (exp_q.size() > 0) chk("t4_rdata", mem_rdata, exp_q.pop_front());
        next_cyc();
        mem_req = 1'b0;
        chk("t4_stall_cnt", stall_cnt, 9);
        pipe_op("t4_ld7", 1'b0, 32'h1C, 32'h0, 2);

        // 5: address errors
        pipe_op("t5_oor", 1'b0, 32'h1002, 32'h0, 1);
        chk("t5_oor_err", addr_err, 1);
        pipe_op("t5_oor_st", 1'b1, 32'h2014, 32'hFFFFFFFF, 1);
        pipe_op("t5_mis", 1'b0, 32'h15, 32'h0, 2);
        chk("t5_mis_err", addr_err, 1);
        chk("t5_stall_cnt", stall_cnt, 11);

        // 6: EN=0 freeze in RD_WAIT
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h18;
        exp_q.push_back(ref_mem[6]);
        @(negedge CLK);
        chk("t6_issue_stall_n", stall_n, 0);
        next_cyc();
        EN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk("t6_en0_csb", sram_csb, 1);
            chk("t6_en0_stall_n", stall_n, 0);
            next_cyc();
        end
        EN = 1'b1;
        @(negedge CLK);
        chk("t6_done_stall_n", stall_n, 1);
        if (exp_q.size() > 0) chk("t6_rdata", mem_rdata, exp_q.pop_front());
        chk("t6_stall_cnt", stall_cnt, 12);
        next_cyc();
        mem_req = 1'b0;

        // 6b: reset pulse mid-read
        mem_req  = 1'b1;
        mem_addr = 32'h14;
        @(negedge CLK);
        chk("t6r_issue_csb", sram_csb, 0);
        next_cyc();
        RSTn = 1'b0;
        #1;
        chk("t6r_csb", sram_csb, 1);
        chk("t6r_web", sram_web, 1);
        chk("t6r_stall_n", stall_n, 1);
        chk("t6r_rdata", mem_rdata, 0);
        chk("t6r_addr_err", addr_err, 0);
        chk("t6r_stall_cnt", stall_cnt, 0);
        mem_req = 1'b0;
        next_cyc();
        RSTn = 1'b1;
        next_cyc();

        // START=0 ignores pipeline requests
        START     = 1'b0;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h1C;
        mem_wdata = 32'h11111111;
        @(negedge CLK);
        chk("t8_start0_csb", sram_csb, 1);
        chk("t8_start0_stall_n", stall_n, 1);
        next_cyc();
        mem_req = 1'b0;
        START   = 1'b1;
        pipe_op("t8_ld", 1'b0, 32'h14, 32'h0, 2);
        pipe_op("t8_ld7", 1'b0, 32'h1C, 32'h0, 2);
        chk("t8_addr_err", addr_err, 0);
        chk("t8_stall_cnt", stall_cnt, 2);

        // saturation of a narrow counter instance
        sc_inc = 1'b1;
        repeat (3) next_cyc();
        chk("sat_mid", sc_cnt, 3);
        repeat (7) next_cyc();
        chk("sat_top", sc_cnt, 7);
        sc_inc = 1'b0;

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
